// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores onto the req/addr_ok/data_ok data bus, stalling until done.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses complete locally with adel/ades instead of reaching the bus.
module dmem_access_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req_valid,
  input  logic          req_wr,
  input  logic [1:0]    req_size,
  input  logic          req_sign,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic          flush,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [DW-1:0] data_wdata,
  output logic [3:0]    data_wstrb,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata,
  output logic          stall,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          adel,
  output logic          ades
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

  state_t        state, stateNext;
  logic          loadSign;
  logic          misaligned, misAccept, busAccept, captureLoad;
  logic [1:0]    sizeNorm;
  logic [3:0]    strbCalc;
  logic [DW-1:0] wdataRep, rdataExt;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size[1] && req_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign sizeNorm  = (req_size == 2'b11) ? 2'b10 : req_size;
  assign misAccept = (state == IDLE) && req_valid && !flush && misaligned;
  assign busAccept = (state == IDLE) && (stateNext == REQ);
  assign resp_valid = (state == DONE);

  // Store lane replication and byte enables, computed from the live request.
  always_comb begin
    wdataRep = req_wdata;
    strbCalc = 4'b1111;
    case (sizeNorm)
      2'b00: begin
        wdataRep = {4{req_wdata[7:0]}};
        strbCalc = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wdataRep = {2{req_wdata[15:0]}};
        strbCalc = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdataRep = req_wdata;
        strbCalc = 4'b1111;
      end
    endcase
  end

  // Load lane extraction uses the registered bus fields of the access in flight.
  always_comb begin
    byteSel  = data_rdata[7:0];
    halfSel  = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    rdataExt = data_rdata;
    case (data_addr[1:0])
      2'b00:   byteSel = data_rdata[7:0];
      2'b01:   byteSel = data_rdata[15:8];
      2'b10:   byteSel = data_rdata[23:16];
      default: byteSel = data_rdata[31:24];
    endcase
    case (data_size)
      2'b00:   rdataExt = {{24{loadSign & byteSel[7]}}, byteSel};
      2'b01:   rdataExt = {{16{loadSign & halfSel[15]}}, halfSel};
      default: rdataExt = data_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    stall       = 1'b0;
    data_req    = 1'b0;
    captureLoad = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          stall     = 1'b1;
          stateNext = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        stall    = 1'b1;
        data_req = 1'b1;
        if (data_addr_ok) begin
          // Address already accepted: a flush must still wait out the data phase.
          if (flush)             stateNext = data_data_ok ? IDLE : DRAIN;
          else if (data_data_ok) begin
            stateNext   = DONE;
            captureLoad = 1'b1;
          end
          else                   stateNext = WAIT;
        end else if (flush) begin
          stateNext = IDLE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (flush)             stateNext = data_data_ok ? IDLE : DRAIN;
        else if (data_data_ok) begin
          stateNext   = DONE;
          captureLoad = 1'b1;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (data_data_ok) stateNext = IDLE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_wr    <= 1'b0;
      data_size  <= 2'b00;
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= 4'b0000;
      loadSign   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      if (busAccept) begin
        data_wr    <= req_wr;
        data_size  <= sizeNorm;
        data_addr  <= req_addr;
        data_wdata <= req_wr ? wdataRep : '0;
        data_wstrb <= req_wr ? strbCalc : 4'b0000;
        loadSign   <= req_sign;
      end
      if (captureLoad)    resp_rdata <= data_wr ? '0 : rdataExt;
      else if (misAccept) resp_rdata <= '0;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic adelQ, adesQ;

  // DONE lasts exactly one cycle, so the flags naturally pulse with resp_valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      adelQ <= 1'b0;
      adesQ <= 1'b0;
    end else begin
      adelQ <= misAccept & ~req_wr;
      adesQ <= misAccept & req_wr;
    end
  end

  assign adel = adelQ;
  assign ades = adesQ;
`else
  assign adel = 1'b0;
  assign ades = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table of single accesses plus hand sequences for flush, drain and reset.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        reqValid = 1'b0, reqWr = 1'b0, reqSign = 1'b0, flush = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic [31:0] reqAddr = '0, reqWdata = '0;
  logic        dataReq, dataWr;
  logic [1:0]  dataSize;
  logic [31:0] dataAddr, dataWdata;
  logic [3:0]  dataWstrb;
  logic        dataAddrOk = 1'b0, dataDataOk = 1'b0;
  logic [31:0] dataRdata = '0;
  logic        stall, respValid, adel, ades;
  logic [31:0] respRdata;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          aDly;
    int          dDly;
    logic [1:0]  expSize;
    logic [31:0] expWdata;
    logic [3:0]  expStrb;
    logic [31:0] expResp;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
  } exp_t;

  vec_t vecs[$];
  exp_t sbQ[$];

  always #5 clk = ~clk;

  dmem_access_ctrl #(.AW(32), .DW(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(reqValid), .req_wr(reqWr), .req_size(reqSize), .req_sign(reqSign),
    .req_addr(reqAddr), .req_wdata(reqWdata), .flush(flush),
    .data_req(dataReq), .data_wr(dataWr), .data_size(dataSize), .data_addr(dataAddr),
    .data_wdata(dataWdata), .data_wstrb(dataWstrb),
    .data_addr_ok(dataAddrOk), .data_data_ok(dataDataOk), .data_rdata(dataRdata),
    .stall(stall), .resp_valid(respValid), .resp_rdata(respRdata),
    .adel(adel), .ades(ades)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: samples 2 time units after the rising edge, away from the negedge driver.
  always @(posedge clk) begin
    #2;
    if (resetn && respValid) begin
      if (sbQ.size() == 0) begin
        chk("spurious_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        chk("resp_rdata", respRdata, e.rdata);
        chk("resp_adel", {31'd0, adel}, {31'd0, e.adel});
        chk("resp_ades", {31'd0, ades}, {31'd0, e.ades});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    reqValid = 1'b1; reqWr = wr; reqSize = size; reqSign = sgn;
    reqAddr = addr; reqWdata = wdata;
  endtask

  // Called on a negedge with the DUT in IDLE; returns on the negedge of the IDLE cycle after DONE.
  task automatic runVec(input vec_t v);
    drive(v.wr, v.size, v.sgn, v.addr, v.wdata);
    sbQ.push_back('{v.expResp, 1'b0, 1'b0});
    #1 chk("c0_stall", {31'd0, stall}, 32'd1);
    chk("c0_data_req", {31'd0, dataReq}, 32'd0);
    @(negedge clk);
    chk("c1_data_req", {31'd0, dataReq}, 32'd1);
    chk("c1_data_wr", {31'd0, dataWr}, {31'd0, v.wr});
    chk("c1_data_size", {30'd0, dataSize}, {30'd0, v.expSize});
    chk("c1_data_addr", dataAddr, v.addr);
    chk("c1_data_wdata", dataWdata, v.expWdata);
    chk("c1_data_wstrb", {28'd0, dataWstrb}, {28'd0, v.expStrb});
    chk("c1_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i < v.aDly; i++) begin
      @(negedge clk);
      chk("req_hold", {31'd0, dataReq}, 32'd1);
      chk("addr_hold", dataAddr, v.addr);
    end
    dataAddrOk = 1'b1;
    if (v.dDly == 0) begin
      dataDataOk = 1'b1;
      dataRdata = v.rdata;
    end
    @(negedge clk);
    dataAddrOk = 1'b0;
    dataDataOk = 1'b0;
    if (v.dDly > 0) begin
      for (int i = 0; i < v.dDly - 1; i++) begin
        chk("wait_req", {31'd0, dataReq}, 32'd0);
        chk("wait_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
      end
      chk("wait_req", {31'd0, dataReq}, 32'd0);
      dataDataOk = 1'b1;
      dataRdata = v.rdata;
      @(negedge clk);
      dataDataOk = 1'b0;
    end
    chk("done_resp_valid", {31'd0, respValid}, 32'd1);
    chk("done_stall", {31'd0, stall}, 32'd0);
    reqValid = 1'b0;
    @(negedge clk);
    chk("idle_resp_valid", {31'd0, respValid}, 32'd0);
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic misTest(input logic wr, input logic [1:0] size, input logic [31:0] addr);
    drive(wr, size, 1'b0, addr, 32'hFFFF_FFFF);
    sbQ.push_back('{32'h0, ~wr, wr});
    #1 chk("mis_c0_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    chk("mis_data_req", {31'd0, dataReq}, 32'd0);
    chk("mis_resp_valid", {31'd0, respValid}, 32'd1);
    chk("mis_adel", {31'd0, adel}, {31'd0, ~wr});
    chk("mis_ades", {31'd0, ades}, {31'd0, wr});
    reqValid = 1'b0;
    @(negedge clk);
    chk("mis_flag_clear", {30'd0, adel, ades}, 32'd0);
    chk("mis_resp_clear", {31'd0, respValid}, 32'd0);
  endtask
`endif

  initial begin
    //           wr    size   sgn   addr          wdata         rdata         aD dD expSize expWdata      strb     expResp
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0,        0, 0, 2'b00, 32'hA5A5_A5A5, 4'b1000, 32'h0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,         32'h8001_1234, 0, 3, 2'b01, 32'h0,         4'b0000, 32'hFFFF_8001});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0,         32'h0000_F700, 1, 0, 2'b00, 32'h0,         4'b0000, 32'h0000_00F7});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_1002, 32'h1234_BEEF, 32'h0,        1, 1, 2'b01, 32'hBEEF_BEEF, 4'b1100, 32'h0});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h0000_4000, 32'h0,         32'hDEAD_BEEF, 2, 0, 2'b10, 32'h0,         4'b0000, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0000, 32'h0,         32'h1234_5680, 0, 2, 2'b00, 32'h0,         4'b0000, 32'hFFFF_FF80});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0,         32'h1234_8001, 0, 1, 2'b01, 32'h0,         4'b0000, 32'h0000_8001});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,        0, 1, 2'b10, 32'hCAFE_F00D, 4'b1111, 32'h0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0000, 32'h0000_01FF, 32'h0,        0, 0, 2'b00, 32'hFFFF_FFFF, 4'b0001, 32'h0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0002, 32'h0,         32'h007F_0000, 0, 0, 2'b00, 32'h0,         4'b0000, 32'h0000_007F});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,         32'h8000_1234, 0, 0, 2'b01, 32'h0,         4'b0000, 32'h0000_1234});
`ifndef MEM_ALIGN_CHECK_EN
    // Without the check a misaligned word goes to the bus untouched.
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_3002, 32'h0,         32'h1122_3344, 0, 0, 2'b10, 32'h0,         4'b0000, 32'h1122_3344});
`endif

    // Reset state
    #3;
    chk("rst_data_req", {31'd0, dataReq}, 32'd0);
    chk("rst_bus_fields", {29'd0, dataWr, dataSize}, 32'd0);
    chk("rst_data_addr", dataAddr, 32'd0);
    chk("rst_data_wdata", dataWdata, 32'd0);
    chk("rst_data_wstrb", {28'd0, dataWstrb}, 32'd0);
    chk("rst_resp", {29'd0, respValid, adel, ades}, 32'd0);
    chk("rst_resp_rdata", respRdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) runVec(vecs[i]);

    // Flush during WAIT: drain the data phase, no response.
    drive(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0);
    #1 chk("dr_c0_stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    chk("dr_c1_req", {31'd0, dataReq}, 32'd1);
    dataAddrOk = 1'b1;
    @(negedge clk);
    dataAddrOk = 1'b0;
    chk("dr_wait_req", {31'd0, dataReq}, 32'd0);
    flush = 1'b1;
    reqValid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("dr_drain_stall", {31'd0, stall}, 32'd1);
    chk("dr_drain_req", {31'd0, dataReq}, 32'd0);
    @(negedge clk);
    chk("dr_drain_stall2", {31'd0, stall}, 32'd1);
    dataDataOk = 1'b1;
    dataRdata = 32'hBAD0_BAD0;
    @(negedge clk);
    dataDataOk = 1'b0;
    chk("dr_idle_stall", {31'd0, stall}, 32'd0);
    chk("dr_idle_resp", {31'd0, respValid}, 32'd0);
    runVec('{1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0, 32'h0BAD_F00D, 0, 0, 2'b10, 32'h0, 4'b0000, 32'h0BAD_F00D});

    // Flush in REQ before addr_ok: request withdrawn.
    drive(1'b1, 2'b10, 1'b0, 32'h0000_6000, 32'h1111_1111);
    @(negedge clk);
    chk("fr_c1_req", {31'd0, dataReq}, 32'd1);
    flush = 1'b1;
    reqValid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("fr_req_drop", {31'd0, dataReq}, 32'd0);
    chk("fr_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk("fr_idle_req", {31'd0, dataReq}, 32'd0);
    chk("fr_idle_resp", {31'd0, respValid}, 32'd0);

    // Reset asserted while in WAIT clears every output at once.
    drive(1'b1, 2'b00, 1'b0, 32'h0000_7005, 32'h0000_005A);
    @(negedge clk);
    dataAddrOk = 1'b1;
    @(negedge clk);
    dataAddrOk = 1'b0;
    reqValid = 1'b0;
    chk("ar_wait_stall", {31'd0, stall}, 32'd1);
    chk("ar_wait_addr", dataAddr, 32'h0000_7005);
    #2 resetn = 1'b0;
    #1;
    chk("ar_data_req", {31'd0, dataReq}, 32'd0);
    chk("ar_bus_fields", {29'd0, dataWr, dataSize}, 32'd0);
    chk("ar_data_addr", dataAddr, 32'd0);
    chk("ar_data_wdata", dataWdata, 32'd0);
    chk("ar_data_wstrb", {28'd0, dataWstrb}, 32'd0);
    chk("ar_resp", {29'd0, respValid, adel, ades}, 32'd0);
    chk("ar_resp_rdata", respRdata, 32'd0);
    chk("ar_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    runVec(vecs[0]);

`ifdef MEM_ALIGN_CHECK_EN
    misTest(1'b0, 2'b10, 32'h0000_3002);
    misTest(1'b1, 2'b01, 32'h0000_3001);
    // A flush alongside a misaligned request suppresses it completely.
    drive(1'b0, 2'b10, 1'b0, 32'h0000_3003, 32'h0);
    flush = 1'b1;
    #1 chk("mis_flush_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    reqValid = 1'b0;
    chk("mis_flush_resp", {31'd0, respValid}, 32'd0);
    chk("mis_flush_flags", {30'd0, adel, ades}, 32'd0);
    @(negedge clk);
`else
    chk("noalign_flags", {30'd0, adel, ades}, 32'd0);
`endif

    @(negedge clk);
    chk("sb_empty", sbQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
